// File: rtl/max10_timer_sequencer.sv
// Avalon-MM master for the interval timer s1 port: expands host START/STOP/SNAP commands
// into timer register sequences and services the timer irq, exporting a tick pulse and count.
module max10_timer_sequencer #(
    parameter int unsigned TICK_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [31:0]           cmd_period,
    input  logic                  cmd_cont,
    input  logic                  cmd_irqen,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_snap,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic [15:0]           tmr_readdata,
    input  logic                  tmr_irq,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  busy
);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StStp   = 4'd1;
    localparam logic [3:0] StPl    = 4'd2;
    localparam logic [3:0] StPh    = 4'd3;
    localparam logic [3:0] StCtl   = 4'd4;
    localparam logic [3:0] StSnw   = 4'd5;
    localparam logic [3:0] StSrl   = 4'd6;
    localparam logic [3:0] StSrh   = 4'd7;
    localparam logic [3:0] StScap  = 4'd8;
    localparam logic [3:0] StIclr  = 4'd9;
    localparam logic [3:0] StIwait = 4'd10;
    localparam logic [3:0] StNop   = 4'd11;

    localparam logic [1:0] OpStart = 2'd0;
    localparam logic [1:0] OpStop  = 2'd1;
    localparam logic [1:0] OpSnap  = 2'd2;

    logic [3:0]            state_q, state_d;
    logic [1:0]            op_q;
    logic [31:0]           per_q;
    logic                  cont_q;
    logic                  irqen_q;
    logic [15:0]           snap_lo_q;
    logic [31:0]           rsp_snap_q;
    logic                  rsp_valid_q;
    logic [TICK_CNT_W-1:0] tick_cnt_q;
    logic                  cmd_accept;

    assign cmd_ready  = (state_q == StIdle) && !tmr_irq;
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (tmr_irq) begin
                    state_d = StIclr;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OpStart, OpStop: state_d = StStp;
                        OpSnap:          state_d = StSnw;
                        default:         state_d = StNop;
                    endcase
                end
            end
            StStp:   state_d = (op_q == OpStart) ? StPl : StIdle;
            StPl:    state_d = StPh;
            StPh:    state_d = StCtl;
            StCtl:   state_d = StIdle;
            StSnw:   state_d = StSrl;
            StSrl:   state_d = StSrh;
            StSrh:   state_d = StScap;
            StScap:  state_d = StIdle;
            StIclr:  state_d = StIwait;
            StIwait: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            per_q       <= 32'd0;
            cont_q      <= 1'b0;
            irqen_q     <= 1'b0;
            snap_lo_q   <= 16'd0;
            rsp_snap_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_q == StScap);
            if (cmd_accept) begin
                op_q    <= cmd_op;
                // A zero period behaves as one cycle, so the preload never underflows.
                per_q   <= (cmd_period == 32'd0) ? 32'd0 : cmd_period - 32'd1;
                cont_q  <= cmd_cont;
                irqen_q <= cmd_irqen;
            end
            if (state_q == StSrh) begin
                snap_lo_q <= tmr_readdata;
            end
            if (state_q == StScap) begin
                rsp_snap_q <= {tmr_readdata, snap_lo_q};
            end
            if ((state_q == StIdle) && tmr_irq) begin
                tick_cnt_q <= tick_cnt_q + {{(TICK_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Bus strobes depend only on registered state and latched command fields.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        case (state_q)
            StStp: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0008;
            end
            StPl: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd2;
                tmr_writedata  = per_q[15:0];
            end
            StPh: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd3;
                tmr_writedata  = per_q[31:16];
            end
            StCtl: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = {12'd0, 1'b0, 1'b1, cont_q, irqen_q};
            end
            StSnw: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd4;
            end
            StSrl: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd4;
            end
            StSrh: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd5;
            end
            StIclr: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd0;
            end
            default: begin
                tmr_chipselect = 1'b0;
            end
        endcase
    end

    assign tick       = (state_q == StIclr);
    assign busy       = (state_q != StIdle);
    assign tick_count = tick_cnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_snap   = rsp_snap_q;

endmodule

// File: tb/tb_max10_timer_sequencer.sv
// Scoreboard bench: driver predicts the timer bus/host events of each command or irq,
// a negedge monitor pops and compares them whenever the DUT shows activity.
module tb_max10_timer_sequencer;

    localparam int TCW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'd0;
    logic [31:0]    cmd_period = 32'd0;
    logic           cmd_cont = 1'b0;
    logic           cmd_irqen = 1'b0;
    logic           rsp_valid;
    logic [31:0]    rsp_snap;
    logic [2:0]     tmr_address;
    logic           tmr_chipselect;
    logic           tmr_write_n;
    logic [15:0]    tmr_writedata;
    logic [15:0]    tmr_readdata = 16'd0;
    logic           tmr_irq = 1'b0;
    logic           tick;
    logic [TCW-1:0] tick_count;
    logic           busy;

    max10_timer_sequencer #(.TICK_CNT_W(TCW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_period    (cmd_period),
        .cmd_cont      (cmd_cont),
        .cmd_irqen     (cmd_irqen),
        .rsp_valid     (rsp_valid),
        .rsp_snap      (rsp_snap),
        .tmr_address   (tmr_address),
        .tmr_chipselect(tmr_chipselect),
        .tmr_write_n   (tmr_write_n),
        .tmr_writedata (tmr_writedata),
        .tmr_readdata  (tmr_readdata),
        .tmr_irq       (tmr_irq),
        .tick          (tick),
        .tick_count    (tick_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // Timer slave model: snapshot on addr4 write, readdata one cycle after address.
    logic [31:0] tmr_cnt = 32'd0;
    logic [31:0] tmr_snap = 32'd0;
    logic        raise_req = 1'b0;

    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) tmr_snap <= tmr_cnt;
        if (tmr_chipselect && tmr_write_n && tmr_address == 3'd4) tmr_readdata <= tmr_snap[15:0];
        else if (tmr_chipselect && tmr_write_n && tmr_address == 3'd5)
            tmr_readdata <= tmr_snap[31:16];
        else tmr_readdata <= 16'd0;
        if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) tmr_irq <= 1'b0;
        else if (raise_req) tmr_irq <= 1'b1;
    end

    typedef struct {
        int          cyc;
        bit          wr;
        logic [2:0]  addr;
        logic [15:0] data;
        bit          tk;
        int          cnt;
        bit          rsp;
        logic [31:0] snap;
    } exp_t;

    exp_t sbq[$];
    int   free_cyc = 0;
    int   model_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic push(input int c, input bit wr, input logic [2:0] a, input logic [15:0] d,
                        input bit tk, input bit rsp, input logic [31:0] snap);
        exp_t e;
        e.cyc = c; e.wr = wr; e.addr = a; e.data = d;
        e.tk = tk; e.cnt = model_cnt % (1 << TCW); e.rsp = rsp; e.snap = snap;
        sbq.push_back(e);
    endtask

    exp_t me;
    bit   mok;
    always @(negedge clk) begin
        if (mon_en && (tmr_chipselect || tick || rsp_valid)) begin
            if (sbq.size() == 0) begin
                chk(1'b0, "unexpected", $sformatf("cyc %0d cs %0b wn %0b a %0d d %h tick %0b rsp %0b",
                    cyc, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, tick, rsp_valid));
            end else begin
                me = sbq.pop_front();
                mok = (me.cyc == cyc) && (tmr_chipselect == !me.rsp)
                    && (me.rsp || (tmr_write_n == !me.wr))
                    && (me.rsp || (tmr_address == me.addr))
                    && (!me.wr || (tmr_writedata == me.data))
                    && (tick == me.tk) && (!me.tk || (int'(tick_count) == me.cnt))
                    && (rsp_valid == me.rsp) && (!me.rsp || (rsp_snap == me.snap));
                chk(mok, "txn", $sformatf(
                    "got cyc %0d cs %0b wn %0b a %0d d %h tick %0b cnt %0d rsp %0b snap %h; want cyc %0d wr %0b a %0d d %h tick %0b cnt %0d rsp %0b snap %h",
                    cyc, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, tick, tick_count,
                    rsp_valid, rsp_snap, me.cyc, me.wr, me.addr, me.data, me.tk, me.cnt, me.rsp,
                    me.snap));
            end
        end
    end

    task automatic idle_wait();
        for (int i = 0; i < 200 && cyc < free_cyc; i++) @(negedge clk);
    endtask

    // Called on a negedge; returns one negedge after the expected acceptance cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                          input logic ien, input bit rst_ph);
        int n; int n_obs; logic [31:0] p;
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_cont = cont; cmd_irqen = ien;
        n = (cyc > free_cyc) ? cyc : free_cyc;
        n_obs = -1;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready) begin n_obs = cyc; break; end
            @(negedge clk);
        end
        chk(n_obs == n, "accept", $sformatf("op %0d accepted at cycle %0d, want %0d", op, n_obs, n));
        p = (per == 32'd0) ? 32'd0 : per - 32'd1;
        case (op)
            2'd0: begin
                push(n + 1, 1, 3'd1, 16'h0008, 0, 0, 0);
                push(n + 2, 1, 3'd2, p[15:0], 0, 0, 0);
                push(n + 3, 1, 3'd3, p[31:16], 0, 0, 0);
                if (!rst_ph) push(n + 4, 1, 3'd1, {12'd0, 1'b0, 1'b1, cont, ien}, 0, 0, 0);
                free_cyc = n + 5;
            end
            2'd1: begin
                push(n + 1, 1, 3'd1, 16'h0008, 0, 0, 0);
                free_cyc = n + 2;
            end
            2'd2: begin
                push(n + 1, 1, 3'd4, 16'h0000, 0, 0, 0);
                push(n + 2, 0, 3'd4, 16'h0000, 0, 0, 0);
                push(n + 3, 0, 3'd5, 16'h0000, 0, 0, 0);
                push(n + 5, 0, 3'd0, 16'h0000, 0, 1, tmr_cnt);
                free_cyc = n + 5;
            end
            default: free_cyc = n + 2;
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        if (rst_ph) begin
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk(!tmr_chipselect && tmr_write_n && !busy && tmr_address == 3'd0, "rst_mid",
                $sformatf("cs %0b wn %0b a %0d busy %0b, want bus idle and not busy",
                          tmr_chipselect, tmr_write_n, tmr_address, busy));
            reset = 1'b0;
            model_cnt = 0;
            free_cyc = cyc;
        end
    endtask

    // Called on a negedge with tmr_irq low and no service in progress.
    task automatic raise_irq();
        int s;
        raise_req = 1'b1;
        s = (cyc + 1 > free_cyc) ? cyc + 1 : free_cyc;
        model_cnt++;
        push(s + 1, 1, 3'd0, 16'h0000, 1, 0, 0);
        free_cyc = s + 3;
        @(negedge clk);
        raise_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] per;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk(!tmr_chipselect, "rst_cs", $sformatf("cs %0b want 0", tmr_chipselect));
        chk(tmr_write_n, "rst_wn", $sformatf("write_n %0b want 1", tmr_write_n));
        chk(tmr_address == 3'd0, "rst_addr", $sformatf("addr %0d want 0", tmr_address));
        chk(tmr_writedata == 16'd0, "rst_wdata", $sformatf("wdata %h want 0", tmr_writedata));
        chk(!busy, "rst_busy", $sformatf("busy %0b want 0", busy));
        chk(!rsp_valid && rsp_snap == 32'd0, "rst_rsp",
            $sformatf("rsp_valid %0b snap %h want 0/0", rsp_valid, rsp_snap));
        chk(!tick && tick_count == '0, "rst_tick",
            $sformatf("tick %0b count %0d want 0/0", tick, tick_count));
        reset = 1'b0;
        mon_en = 1'b1;
        free_cyc = cyc;
        @(negedge clk);
        chk(cmd_ready, "rst_ready", $sformatf("cmd_ready %0b want 1", cmd_ready));

        do_cmd(2'd0, 32'd50000, 1'b1, 1'b1, 1'b0);
        idle_wait();
        for (int i = 0; i < 17; i++) begin
            raise_irq();
            idle_wait();
        end
        tmr_cnt = 32'h0001_2345;
        do_cmd(2'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        idle_wait();
        do_cmd(2'd0, 32'd1234, 1'b0, 1'b1, 1'b0);
        raise_irq();
        do_cmd(2'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        idle_wait();
        do_cmd(2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        do_cmd(2'd0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        do_cmd(2'd3, 32'd77, 1'b1, 1'b1, 1'b0);
        idle_wait();
        raise_irq();
        idle_wait();
        do_cmd(2'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        do_cmd(2'd1, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: per = 32'd0;
                1: per = 32'd1;
                2: per = 32'h0001_0000;
                default: per = $urandom;
            endcase
            if (op == 2'd2) begin
                idle_wait();
                tmr_cnt = $urandom;
            end
            do_cmd(op, per, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) raise_irq();
        end

        idle_wait();
        repeat (4) @(negedge clk);
        chk(sbq.size() == 0, "drain", $sformatf("%0d expected events never seen, want 0",
                                               sbq.size()));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
